// File: rtl/mul_kn_inv_pkg.sv
// cordic_pkg: shared CORDIC widths, the Kn-inverse constant and the sample type
package cordic_pkg;
  localparam int CORDIC_W = 12;
  localparam int CORDIC_FXP_SHIFT = 10;
  localparam int KN_INV_Q10 = 1686;
  typedef logic signed [CORDIC_W-1:0] cordic_sample_t;
endpackage

// File: rtl/kn_inv_lane.sv
// kn_inv_lane: one 4-stage shift-add lane computing d*1686/1024 (floor)
// KN_INV_SAT_EN selects clamping with an overflow flag; otherwise the result wraps.
module kn_inv_lane
  import cordic_pkg::*;
#(
  parameter int W = CORDIC_W,
  parameter int FXP_SHIFT = CORDIC_FXP_SHIFT
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                ce,
  input  logic signed [W-1:0] i_d,
  output logic signed [W-1:0] o_q,
  output logic                o_ovf
);
  logic signed [2*W-1:0] r_v, r_p0, r_p1, r_p2, r_q0, r_q1, w_s;
  logic signed [W-1:0] w_res;
  logic w_ovf;
  assign w_s = r_q0 + r_q1;
`ifdef KN_INV_SAT_EN
  localparam logic signed [2*W-1:0] L_MAX = (2*W)'(2**(W-1) - 1);
  localparam logic signed [2*W-1:0] L_MIN = -(2*W)'(2**(W-1));
  logic signed [2*W-1:0] w_sh;
  assign w_sh  = w_s >>> FXP_SHIFT;
  assign w_ovf = (w_sh > L_MAX) || (w_sh < L_MIN);
  assign w_res = w_sh > L_MAX ? L_MAX[W-1:0] : w_sh < L_MIN ? L_MIN[W-1:0] : w_sh[W-1:0];
`else
  assign w_ovf = 1'b0;
  assign w_res = W'(w_s >>> FXP_SHIFT);
`endif
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_v   <= '0;
      r_p0  <= '0;
      r_p1  <= '0;
      r_p2  <= '0;
      r_q0  <= '0;
      r_q1  <= '0;
      o_q   <= '0;
      o_ovf <= 1'b0;
    end else if (ce) begin
      r_v   <= {{W{i_d[W-1]}}, i_d};
      r_p0  <= (r_v <<< 10) + (r_v <<< 9);
      r_p1  <= (r_v <<< 7) + (r_v <<< 4);
      r_p2  <= (r_v <<< 2) + (r_v <<< 1);
      r_q0  <= r_p0 + r_p1;
      r_q1  <= r_p2;
      o_q   <= w_res;
      o_ovf <= w_ovf;
    end
  end
endmodule

// File: rtl/mul_kn_inv.sv
// mul_kn_inv: pipelined I/Q multiply by An=1686/1024 with valid tag and ce stall
// Optional output saturation is enabled by defining KN_INV_SAT_EN.
module mul_kn_inv
  import cordic_pkg::*;
#(
  parameter int W = CORDIC_W,
  parameter int FXP_SHIFT = CORDIC_FXP_SHIFT
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                ce,
  input  logic                valid_in,
  input  logic signed [W-1:0] x_in,
  input  logic signed [W-1:0] y_in,
  output logic                valid_out,
  output logic signed [W-1:0] x_out,
  output logic signed [W-1:0] y_out,
  output logic                ovf_out
);
  logic [3:0] r_vld;
  logic w_ovf_x, w_ovf_y;
  kn_inv_lane #(.W(W), .FXP_SHIFT(FXP_SHIFT)) u_x (
    .clock(clock), .reset_n(reset_n), .ce(ce), .i_d(x_in), .o_q(x_out), .o_ovf(w_ovf_x)
  );
  kn_inv_lane #(.W(W), .FXP_SHIFT(FXP_SHIFT)) u_y (
    .clock(clock), .reset_n(reset_n), .ce(ce), .i_d(y_in), .o_q(y_out), .o_ovf(w_ovf_y)
  );
  // both flags are already registered alongside the lane outputs
  assign ovf_out   = w_ovf_x | w_ovf_y;
  assign valid_out = r_vld[3];
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_vld <= '0;
    else if (ce) r_vld <= {r_vld[2:0], valid_in};
  end
endmodule

// File: tb/tb_mul_kn_inv.sv
// tb_mul_kn_inv: directed self-checking bench for mul_kn_inv (follows KN_INV_SAT_EN)
module tb_mul_kn_inv;
  import cordic_pkg::*;
  logic clock = 1'b0, reset_n = 1'b0, ce = 1'b1, valid_in = 1'b0;
  logic signed [11:0] x_in = '0, y_in = '0, x_out, y_out;
  logic valid_out, ovf_out;
  int n_run = 0, n_fail = 0;
  mul_kn_inv dut (
    .clock(clock), .reset_n(reset_n), .ce(ce), .valid_in(valid_in), .x_in(x_in), .y_in(y_in),
    .valid_out(valid_out), .x_out(x_out), .y_out(y_out), .ovf_out(ovf_out)
  );
  always #5 clock = ~clock;
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic logic signed [11:0] mdl(input int v, output logic o);
    int s;
    s = (v * KN_INV_Q10) >>> 10;
`ifdef KN_INV_SAT_EN
    o = (s > 2047) || (s < -2048);
    mdl = s > 2047 ? 12'sd2047 : s < -2048 ? -12'sd2048 : s[11:0];
`else
    o = 1'b0;
    mdl = s[11:0];
`endif
  endfunction
  task automatic put(input int x, input int y, input logic v);
    x_in = 12'(x);
    y_in = 12'(y);
    valid_in = v;
  endtask
  task automatic run1(input string tag, input int x, input int y, input int ex, input int ey, input int eo);
    put(x, y, 1'b1);
    tick();
    put(0, 0, 1'b0);
    repeat (3) tick();
    chk({tag, "_x"}, x_out, ex);
    chk({tag, "_y"}, y_out, ey);
    chk({tag, "_v"}, valid_out, 1);
    chk({tag, "_ovf"}, ovf_out, eo);
    tick();
    chk({tag, "_v_drop"}, valid_out, 0);
  endtask
  int sx[8] = '{100, -100, 2047, -2048, 1, -1, 777, -555};
  int sy[8] = '{0, 512, -2048, 2047, 1023, -1023, 3, -3};
  logic signed [11:0] mx[4], my[4];
  logic mo[4], mv[4];
  logic ox, oy;
  int sent, vcnt;
  initial begin
    tick();
    tick();
    chk("rst_x", x_out, 0);
    chk("rst_y", y_out, 0);
    chk("rst_v", valid_out, 0);
    chk("rst_ovf", ovf_out, 0);
    reset_n = 1'b1;
    tick();
    run1("unity", 1024, -1024, 1686, -1686, 0);
    run1("floor", 600, -1, 987, -2, 0);
`ifdef KN_INV_SAT_EN
    run1("ovf", 2047, -2048, 2047, -2048, 1);
`else
    run1("ovf", 2047, -2048, -726, 724, 0);
`endif
    // pipeline now holds zeros; mirror it with a 4-stage reference
    for (int i = 0; i < 4; i++) begin
      mx[i] = '0;
      my[i] = '0;
      mo[i] = 1'b0;
      mv[i] = 1'b0;
    end
    sent = 0;
    vcnt = 0;
    for (int c = 0; c < 40; c++) begin
      ce = (c % 3 == 0);
      if (sent < 8) put(sx[sent], sy[sent], 1'b1);
      else put(0, 0, 1'b0);
      if (ce) begin
        for (int i = 3; i > 0; i--) begin
          mx[i] = mx[i-1];
          my[i] = my[i-1];
          mo[i] = mo[i-1];
          mv[i] = mv[i-1];
        end
        mx[0] = mdl(int'(x_in), ox);
        my[0] = mdl(int'(y_in), oy);
        mo[0] = ox | oy;
        mv[0] = valid_in;
        if (sent < 8) sent++;
      end
      tick();
      if (ce && valid_out) vcnt++;
      chk("stall_x", x_out, mx[3]);
      chk("stall_y", y_out, my[3]);
      chk("stall_v", valid_out, mv[3]);
      chk("stall_ovf", ovf_out, mo[3]);
    end
    chk("stall_vcnt", vcnt, 8);
    ce = 1'b1;
    put(100, -100, 1'b1);
    tick();
    put(1024, 1024, 1'b1);
    tick();
    tick();
    put(0, 0, 1'b0);
    tick();
    chk("pre_rst_x", x_out, 164);
    chk("pre_rst_y", y_out, -165);
    chk("pre_rst_v", valid_out, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_x", x_out, 0);
    chk("mid_rst_y", y_out, 0);
    chk("mid_rst_v", valid_out, 0);
    chk("mid_rst_ovf", ovf_out, 0);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("no_stale_v", valid_out, 0);
    end
    run1("post_rst", 512, 512, 843, 843, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
